// File: rtl/nn_seq_ctrl_if.sv
// Handshake bundle between the segment buffer / NN engine side and nn_seq_ctrl.
interface nn_seq_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic             seg_shift_start;
  logic             seg_done;
  logic             nn_dv;
  logic [1:0]       nn_result;
  logic             clr_err;
  logic             nn_start;
  logic             result_dv;
  logic [1:0]       result;
  logic             busy;
  logic             overrun;
  logic             timeout_err;
  logic [CNT_W-1:0] det_count;

  // Driver of segment/NN events, consumer of controller status.
  modport master (
    output enable, seg_shift_start, seg_done, nn_dv, nn_result, clr_err,
    input  nn_start, result_dv, result, busy, overrun, timeout_err, det_count
  );

  // The sequencing controller itself.
  modport slave (
    input  enable, seg_shift_start, seg_done, nn_dv, nn_result, clr_err,
    output nn_start, result_dv, result, busy, overrun, timeout_err, det_count
  );
endinterface

// File: rtl/nn_seq_ctrl.sv
// Sequences segment load, NN run and result hand-off, with one-deep
// pending-segment queue, per-phase timeout and sticky error flags.
module nn_seq_ctrl #(
  parameter int unsigned TO_CYCLES = 65535,
  parameter int unsigned CNT_W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  nn_seq_ctrl_if.slave bus
);

  localparam int unsigned TMO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_OUT,
    ST_ERR
  } state_e;

  state_e           state, state_nxt;
  logic             pend, pend_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             start_en_c;
  logic             set_ovr_c;
  logic             set_tmo_c;
  logic             cap_c;
  logic             cnt_inc_c;

  assign start_en_c = bus.seg_shift_start && bus.enable;

  // State, pending flag and phase timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pend    <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // Next-state, pending-segment and event decode.
  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend;
    tmo_cnt_nxt = tmo_cnt;
    set_ovr_c   = 1'b0;
    set_tmo_c   = 1'b0;
    cap_c       = 1'b0;
    cnt_inc_c   = 1'b0;

    // A new segment while busy is queued once; a second one is dropped.
    if ((state != ST_IDLE) && start_en_c) begin
      if (pend) set_ovr_c = 1'b1;
      else      pend_nxt  = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (start_en_c) begin
          state_nxt   = ST_LOAD;
          tmo_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (bus.seg_done) begin
          state_nxt   = ST_RUN;
          tmo_cnt_nxt = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_ERR;
          set_tmo_c = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.nn_dv) begin
          state_nxt = ST_OUT;
          cap_c     = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_ERR;
          set_tmo_c = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      ST_OUT: begin
        cnt_inc_c = (bus.result != 2'd0);
        // Queued or freshly arriving segment goes straight to LOAD.
        if (pend || start_en_c) begin
          state_nxt   = ST_LOAD;
          pend_nxt    = 1'b0;
          tmo_cnt_nxt = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_nxt = ST_IDLE;
        pend_nxt  = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  // Registered outputs; set events take priority over clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.nn_start    <= 1'b0;
      bus.result_dv   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.result      <= 2'd0;
      bus.overrun     <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.det_count   <= '0;
    end else begin
      bus.nn_start  <= (state_nxt == ST_RUN);
      bus.result_dv <= (state_nxt == ST_OUT);
      bus.busy      <= (state_nxt != ST_IDLE);
      if (cap_c) bus.result <= bus.nn_result;

      if (set_ovr_c)        bus.overrun <= 1'b1;
      else if (bus.clr_err) bus.overrun <= 1'b0;

      if (set_tmo_c)        bus.timeout_err <= 1'b1;
      else if (bus.clr_err) bus.timeout_err <= 1'b0;

      if (cnt_inc_c) begin
        if (bus.det_count != CNT_MAX) bus.det_count <= bus.det_count + CNT_W'(1);
      end else if (bus.clr_err) begin
        bus.det_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Bench for nn_seq_ctrl: two instances (short timeout / 2-bit counter, and
// defaults) driven in lockstep, checked every cycle against a phase model.
module tb_nn_seq_ctrl;

  localparam int unsigned TO_A = 16;
  localparam int unsigned CW_A = 2;
  localparam int unsigned TO_B = 65535;
  localparam int unsigned CW_B = 8;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_OUT  = 3;
  localparam int P_ERR  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, sss, sd, dv, clr;
  logic [1:0] nres;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_start [2];
  int cnt_dv    [2];

  // Reference model: phase, cycles spent waiting, queued segment, outputs.
  int m_ph   [2];
  int m_wait [2];
  bit m_q    [2];
  int m_res  [2];
  bit m_ovr  [2];
  bit m_terr [2];
  int m_det  [2];

  logic [1:0] sat_res [7] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2};

  always #5 clk = ~clk;

  nn_seq_ctrl_if #(.CNT_W(CW_A)) ifa ();
  nn_seq_ctrl_if #(.CNT_W(CW_B)) ifb ();

  assign ifa.enable = en;  assign ifa.seg_shift_start = sss; assign ifa.seg_done = sd;
  assign ifa.nn_dv  = dv;  assign ifa.nn_result = nres;      assign ifa.clr_err  = clr;
  assign ifb.enable = en;  assign ifb.seg_shift_start = sss; assign ifb.seg_done = sd;
  assign ifb.nn_dv  = dv;  assign ifb.nn_result = nres;      assign ifb.clr_err  = clr;

  nn_seq_ctrl #(.TO_CYCLES(TO_A), .CNT_W(CW_A)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  nn_seq_ctrl #(.TO_CYCLES(TO_B), .CNT_W(CW_B)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_IDLE; m_wait[k] = 0; m_q[k] = 1'b0; m_res[k] = 0;
      m_ovr[k] = 1'b0;  m_terr[k] = 1'b0; m_det[k] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step(int k, int to_c, int cmax);
    bit se      = sss && en;
    bit q_n     = m_q[k];
    bit ovr_set = 1'b0;
    bit te_set  = 1'b0;
    bit inc     = 1'b0;
    int ph      = m_ph[k];
    if (ph != P_IDLE && se) begin
      if (m_q[k]) ovr_set = 1'b1;
      else        q_n     = 1'b1;
    end
    case (ph)
      P_IDLE: if (se) begin m_ph[k] = P_LOAD; m_wait[k] = 0; end
      P_LOAD, P_RUN: begin
        if ((ph == P_LOAD && sd) || (ph == P_RUN && dv)) begin
          if (ph == P_RUN) m_res[k] = int'(nres);
          m_ph[k] = (ph == P_LOAD) ? P_RUN : P_OUT;
          m_wait[k] = 0;
        end else if (m_wait[k] == to_c - 1) begin
          m_ph[k] = P_ERR; te_set = 1'b1;
        end else begin
          m_wait[k]++;
        end
      end
      P_OUT: begin
        inc = (m_res[k] != 0);
        if (m_q[k] || se) begin m_ph[k] = P_LOAD; m_wait[k] = 0; q_n = 1'b0; end
        else m_ph[k] = P_IDLE;
      end
      default: begin m_ph[k] = P_IDLE; q_n = 1'b0; end
    endcase
    m_q[k] = q_n;
    if (ovr_set) m_ovr[k] = 1'b1; else if (clr) m_ovr[k] = 1'b0;
    if (te_set)  m_terr[k] = 1'b1; else if (clr) m_terr[k] = 1'b0;
    if (inc) begin
      if (m_det[k] < cmax) m_det[k]++;
    end else if (clr) begin
      m_det[k] = 0;
    end
  endtask

  task automatic cmp_vals(string p, int k, logic st, logic rdv, logic [1:0] r,
                          logic bz, logic ov, logic te, logic [7:0] det);
    check({p, "_nn_start"},    32'(st),  32'(m_ph[k] == P_RUN));
    check({p, "_result_dv"},   32'(rdv), 32'(m_ph[k] == P_OUT));
    check({p, "_busy"},        32'(bz),  32'(m_ph[k] != P_IDLE));
    check({p, "_result"},      32'(r),   32'(m_res[k]));
    check({p, "_overrun"},     32'(ov),  32'(m_ovr[k]));
    check({p, "_timeout_err"}, 32'(te),  32'(m_terr[k]));
    check({p, "_det_count"},   32'(det), 32'(m_det[k]));
  endtask

  // One clock: model steps with current inputs, DUT outputs sampled at negedge.
  task automatic cycle();
    model_step(0, int'(TO_A), 3);
    model_step(1, int'(TO_B), 255);
    @(negedge clk);
    cmp_vals("a", 0, ifa.nn_start, ifa.result_dv, ifa.result, ifa.busy,
             ifa.overrun, ifa.timeout_err, 8'(ifa.det_count));
    cmp_vals("b", 1, ifb.nn_start, ifb.result_dv, ifb.result, ifb.busy,
             ifb.overrun, ifb.timeout_err, ifb.det_count);
    if (ifa.nn_start)  cnt_start[0]++;
    if (ifb.nn_start)  cnt_start[1]++;
    if (ifa.result_dv) cnt_dv[0]++;
    if (ifb.result_dv) cnt_dv[1]++;
  endtask

  task automatic step(bit s, bit d, bit v, logic [1:0] r, bit c);
    en = 1'b1; sss = s; sd = d; dv = v; nres = r; clr = c;
    cycle();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic do_reset();
    en = 1'b1; sss = 1'b0; sd = 1'b0; dv = 1'b0; nres = 2'd0; clr = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_a_nn_start", 32'(ifa.nn_start), 32'd0);
    check("rst_a_busy",     32'(ifa.busy),     32'd0);
    check("rst_b_nn_start", 32'(ifb.nn_start), 32'd0);
    check("rst_b_busy",     32'(ifb.busy),     32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin cnt_start[k] = 0; cnt_dv[k] = 0; end
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0; sss = 1'b0; sd = 1'b0; dv = 1'b0; nres = 2'd0; clr = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin cnt_start[k] = 0; cnt_dv[k] = 0; end
    @(negedge clk);
    @(negedge clk);
    check("init_result_dv",   32'(ifa.result_dv),   32'd0);
    check("init_result",      32'(ifb.result),      32'd0);
    check("init_overrun",     32'(ifa.overrun),     32'd0);
    check("init_timeout_err", 32'(ifa.timeout_err), 32'd0);
    check("init_det_count",   32'(ifb.det_count),   32'd0);
    reset = 1'b1;

    // Nominal flow on the default instance: 20-cycle load, 100-cycle run.
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(19);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(99);
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    check("nom_result_dv", 32'(ifb.result_dv), 32'd1);
    check("nom_nn_start",  32'(ifb.nn_start),  32'd0);
    check("nom_result",    32'(ifb.result),    32'd2);
    check("nom_run_len",   32'(cnt_start[1]),  32'd100);
    idle(1);
    check("nom_det_count", 32'(ifb.det_count), 32'd1);
    check("nom_busy",      32'(ifb.busy),      32'd0);

    // Back-to-back: second start queued, third dropped as overrun.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    check("b2b_overrun", 32'(ifa.overrun), 32'd1);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    idle(1);
    check("b2b_no_idle", 32'(ifa.busy), 32'd1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    check("b2b_second_run", 32'(ifa.nn_start), 32'd1);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    idle(2);
    check("b2b_dv_count_a", 32'(cnt_dv[0]), 32'd2);
    check("b2b_dv_count_b", 32'(cnt_dv[1]), 32'd2);
    check("b2b_result",     32'(ifa.result), 32'd3);

    // Load timeout: 16 LOAD cycles, then one ERR cycle, then IDLE.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(15);
    check("tmo_pre_err", 32'(ifa.timeout_err), 32'd0);
    idle(1);
    check("tmo_err_set",  32'(ifa.timeout_err), 32'd1);
    check("tmo_err_busy", 32'(ifa.busy),        32'd1);
    idle(1);
    check("tmo_idle",     32'(ifa.busy),        32'd0);
    check("tmo_no_start", 32'(cnt_start[0]),    32'd0);
    check("tmo_b_none",   32'(ifb.timeout_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("tmo_clr", 32'(ifa.timeout_err), 32'd0);

    // seg_done coincident with expiry wins; nn_dv in IDLE is ignored.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(15);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    check("race_run",    32'(ifa.nn_start),    32'd1);
    check("race_no_tmo", 32'(ifa.timeout_err), 32'd0);
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    check("idle_dv_ignored", 32'(ifa.result_dv), 32'd0);
    check("idle_dv_result",  32'(ifa.result),    32'd0);

    // Reset during RUN drops the segment; later nn_dv produces nothing.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(3);
    check("mid_run_start", 32'(ifa.nn_start), 32'd1);
    do_reset();
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    check("post_rst_dv",     32'(ifa.result_dv), 32'd0);
    check("post_rst_result", 32'(ifa.result),    32'd0);

    // Saturation: five nonzero and two zero results.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      step(1'b0, 1'b0, 1'b1, sat_res[i], 1'b0);
      idle(1);
    end
    check("sat_det_a", 32'(ifa.det_count), 32'd3);
    check("sat_det_b", 32'(ifb.det_count), 32'd5);

    // Randomised traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        en   = ($urandom_range(7) != 0);
        sss  = ($urandom_range(7) == 0);
        sd   = ($urandom_range(9) == 0);
        dv   = ($urandom_range(9) == 0);
        nres = 2'($urandom_range(3));
        clr  = ($urandom_range(19) == 0);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
